// File: rtl/hydra_pkt_gen.sv
// hydra_pkt_gen: multi-port framed packet source (sop, header, payload, eop) with per-port pause, gap and stop control
module hydra_pkt_gen #(
  parameter int PORT_NUM   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 9,
  parameter int PRI_WIDTH  = 3,
  parameter int DEST_WIDTH = 4,
  parameter int GAP_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_we,
  input  logic [$clog2(PORT_NUM)-1:0]     cfg_port,
  input  logic [LEN_WIDTH-1:0]            cfg_len,
  input  logic [PRI_WIDTH-1:0]            cfg_prio,
  input  logic [DEST_WIDTH-1:0]           cfg_dest,
  input  logic [CNT_WIDTH-1:0]            cfg_pkts,
  input  logic [GAP_WIDTH-1:0]            cfg_gap,
  input  logic [PORT_NUM-1:0]             start,
  input  logic [PORT_NUM-1:0]             stop,
  input  logic [PORT_NUM-1:0]             pause,
  output logic [PORT_NUM-1:0]             wr_sop,
  output logic [PORT_NUM-1:0]             wr_eop,
  output logic [PORT_NUM-1:0]             wr_vld,
  output logic [PORT_NUM*DATA_WIDTH-1:0]  wr_data,
  output logic [PORT_NUM-1:0]             busy,
  output logic [PORT_NUM-1:0]             done,
  output logic [PORT_NUM*CNT_WIDTH-1:0]   pkt_sent
);
  localparam int PW = $clog2(PORT_NUM);
  typedef enum logic [2:0] {IDLE, SOP, HDR, PAY, EOP, GAP} state_t;
  if (LEN_WIDTH + PRI_WIDTH + DEST_WIDTH != DATA_WIDTH) begin : g_bad_widths
    $error("hydra_pkt_gen: LEN_WIDTH+PRI_WIDTH+DEST_WIDTH must equal DATA_WIDTH");
  end
  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    state_t                 st;
    logic [LEN_WIDTH-1:0]   len, idx;
    logic [PRI_WIDTH-1:0]   prio;
    logic [DEST_WIDTH-1:0]  dest;
    logic [CNT_WIDTH-1:0]   pkts, rem, sent;
    logic [GAP_WIDTH-1:0]   gap, gcnt;
    logic [15:0]            seq;
    logic [DATA_WIDTH-1:0]  data;
    logic                   lim, stp, sop, eop, vld, bsy, dn;
    logic                   wr, stp_now;
    assign wr      = cfg_we && cfg_port == PW'(p);
    assign stp_now = stp | stop[p];
    // A write coinciding with start must feed the packet count straight through
    always_ff @(posedge clk)
      if (rst) begin
        st   <= IDLE;
        len  <= '0;
        idx  <= '0;
        prio <= '0;
        dest <= '0;
        pkts <= '0;
        rem  <= '0;
        sent <= '0;
        gap  <= '0;
        gcnt <= '0;
        seq  <= '0;
        data <= '0;
        lim  <= 1'b0;
        stp  <= 1'b0;
        sop  <= 1'b0;
        eop  <= 1'b0;
        vld  <= 1'b0;
        bsy  <= 1'b0;
        dn   <= 1'b0;
      end else begin
        sop  <= 1'b0;
        eop  <= 1'b0;
        vld  <= 1'b0;
        dn   <= 1'b0;
        data <= (st == HDR || st == PAY) ? data : '0;
        if (st != IDLE) stp <= stp_now;
        case (st)
          IDLE: begin
            if (wr) begin
              len  <= cfg_len;
              prio <= cfg_prio;
              dest <= cfg_dest;
              pkts <= cfg_pkts;
              gap  <= cfg_gap;
            end
            if (start[p]) begin
              rem <= wr ? cfg_pkts : pkts;
              lim <= (wr ? cfg_pkts : pkts) != '0;
              seq <= '0;
              stp <= 1'b0;
              bsy <= 1'b1;
              st  <= SOP;
            end
          end
          SOP: if (!pause[p]) begin
            sop <= 1'b1;
            st  <= HDR;
          end
          HDR: if (!pause[p]) begin
            vld  <= 1'b1;
            data <= {len, prio, dest};
            idx  <= '0;
            st   <= PAY;
          end
          PAY: if (!pause[p]) begin
            vld  <= 1'b1;
            data <= DATA_WIDTH'(seq);
            seq  <= seq + 16'd1;
            idx  <= idx + LEN_WIDTH'(1);
            if (idx == len) st <= EOP;
          end
          EOP: begin
            eop  <= 1'b1;
            sent <= sent + CNT_WIDTH'(1);
            if (lim) rem <= rem - CNT_WIDTH'(1);
            if ((lim && rem == CNT_WIDTH'(1)) || stp_now) begin
              st  <= IDLE;
              dn  <= 1'b1;
              bsy <= 1'b0;
            end else if (gap == '0) st <= SOP;
            else begin
              gcnt <= gap;
              st   <= GAP;
            end
          end
          GAP: if (stp_now) begin
            st  <= IDLE;
            dn  <= 1'b1;
            bsy <= 1'b0;
          end else if (gcnt == GAP_WIDTH'(1)) st <= SOP;
          else gcnt <= gcnt - GAP_WIDTH'(1);
          default: st <= IDLE;
        endcase
      end
    assign wr_sop[p]                            = sop;
    assign wr_eop[p]                            = eop;
    assign wr_vld[p]                            = vld;
    assign busy[p]                              = bsy;
    assign done[p]                              = dn;
    assign wr_data[p*DATA_WIDTH +: DATA_WIDTH]  = data;
    assign pkt_sent[p*CNT_WIDTH +: CNT_WIDTH]   = sent;
  end
endmodule
